// File: rtl/stream_pkg.sv
// Shared types and helpers for the frame/pixel streamers that feed the layer pipeline.
// Holds the streamer FSM encoding and the address-width helper used for parameter defaults.
package stream_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } stream_state_t;

    localparam int FIFO_DEPTH = 2;
    localparam int OCC_WIDTH  = 2;

    // Ceiling log2, never below 1 so a degenerate 1-pixel image still gets an address bit.
    function automatic int log2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/image_stream_source_if.sv
// Bundle between the image streamer, its frame RAM and the downstream convolutional layer.
// The master side is the streamer; the slave side is the RAM/layer environment.
interface image_stream_source_if #(
    parameter int D_WIDTH    = 8,
    parameter int D_CHANNELS = 1,
    parameter int ADDR_WIDTH = 10
);

    logic                          start;
    logic                          stall;
    logic                          mem_rd_en;
    logic [ADDR_WIDTH-1:0]         mem_addr;
    logic [D_WIDTH*D_CHANNELS-1:0] mem_rd_data;
    logic [D_WIDTH*D_CHANNELS-1:0] pixel_data;
    logic                          pixel_en;
    logic                          busy;
    logic                          frame_done;

    modport master (
        input  start,
        input  stall,
        input  mem_rd_data,
        output mem_rd_en,
        output mem_addr,
        output pixel_data,
        output pixel_en,
        output busy,
        output frame_done
    );

    modport slave (
        output start,
        output stall,
        output mem_rd_data,
        input  mem_rd_en,
        input  mem_addr,
        input  pixel_data,
        input  pixel_en,
        input  busy,
        input  frame_done
    );

endinterface

// File: rtl/prefetch_fifo2.sv
// Two-entry register FIFO absorbing one cycle of RAM read latency under downstream stall.
// Head is always presented; the owner qualifies it with occupancy.
module prefetch_fifo2
    import stream_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_i,
    input  logic                 wr_i,
    input  logic [WIDTH-1:0]     wr_data_i,
    input  logic                 rd_i,
    output logic [WIDTH-1:0]     head_o,
    output logic [OCC_WIDTH-1:0] occ_o
);

    logic [WIDTH-1:0]     mem_q [FIFO_DEPTH];
    logic [WIDTH-1:0]     mem_d [FIFO_DEPTH];
    logic                 wr_ptr_q, wr_ptr_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic [OCC_WIDTH-1:0] occ_q, occ_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q + OCC_WIDTH'(wr_i) - OCC_WIDTH'(rd_i);
        if (clr_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            occ_d    = '0;
        end else begin
            if (wr_i) begin
                mem_d[wr_ptr_q] = wr_data_i;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (rd_i) begin
                rd_ptr_d = ~rd_ptr_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign head_o = mem_q[rd_ptr_q];
    assign occ_o  = occ_q;

    // The owner's credit scheme must never overfill or drain an empty buffer.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(wr_i && !rd_i && !clr_i && (occ_q == 2'd2)));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(rd_i && (occ_q == 2'd0)));
    a_occ_range: assert property (@(posedge clk) disable iff (!rst_n)
        occ_q != 2'd3);

endmodule

// File: rtl/image_stream_source.sv
// Raster-order frame streamer: reads one IMAGE_SIZE x IMAGE_SIZE image from a synchronous RAM
// and hands pixels to the first convolutional layer, tolerating downstream stall.
module image_stream_source
    import stream_pkg::*;
#(
    parameter int D_WIDTH    = 8,
    parameter int D_CHANNELS = 1,
    parameter int IMAGE_SIZE = 28,
    parameter int ADDR_WIDTH = log2(IMAGE_SIZE * IMAGE_SIZE)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    image_stream_source_if.master  bus
);

    localparam int PIX_W   = D_WIDTH * D_CHANNELS;
    localparam int NUM_PIX = IMAGE_SIZE * IMAGE_SIZE;
    localparam int CNT_W   = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] NUM_PIX_C  = CNT_W'(NUM_PIX);
    localparam logic [CNT_W-1:0] LAST_PIX_C = CNT_W'(NUM_PIX - 1);

    stream_state_t        state_q, state_d;
    logic [CNT_W-1:0]     rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]     out_cnt_q, out_cnt_d;
    logic                 inflight_q, inflight_d;

    logic                 clr;
    logic                 consume;
    logic                 rd_en;
    logic [2:0]           credit;
    logic [PIX_W-1:0]     head;
    logic [OCC_WIDTH-1:0] occ;

    // Credit counts buffered plus in-flight pixels after this cycle's consume; a read is
    // only issued when its data is guaranteed a free slot on return.
    always_comb begin
        clr     = (state_q == IDLE);
        consume = (occ != '0) && !bus.stall;
        credit  = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, consume};
        rd_en   = (state_q == STREAM) && (rd_cnt_q < NUM_PIX_C) && (credit < 3'd2);
    end

    always_comb begin
        state_d    = state_q;
        rd_cnt_d   = rd_cnt_q + CNT_W'(rd_en);
        out_cnt_d  = out_cnt_q + CNT_W'(consume);
        inflight_d = rd_en;
        case (state_q)
            IDLE: begin
                rd_cnt_d   = '0;
                out_cnt_d  = '0;
                inflight_d = 1'b0;
                if (bus.start) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (consume && (out_cnt_q == LAST_PIX_C)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rd_cnt_q   <= '0;
            out_cnt_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_cnt_q   <= rd_cnt_d;
            out_cnt_q  <= out_cnt_d;
            inflight_q <= inflight_d;
        end
    end

    // Returning RAM data is captured unconditionally; the credit check already reserved room.
    prefetch_fifo2 #(
        .WIDTH (PIX_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (clr),
        .wr_i      (inflight_q),
        .wr_data_i (bus.mem_rd_data),
        .rd_i      (consume),
        .head_o    (head),
        .occ_o     (occ)
    );

    assign bus.mem_rd_en  = rd_en;
    assign bus.mem_addr   = rd_cnt_q[ADDR_WIDTH-1:0];
    assign bus.pixel_en   = consume;
    assign bus.pixel_data = (occ != '0) ? head : '0;
    assign bus.busy       = (state_q != IDLE);
    assign bus.frame_done = (state_q == DONE);

endmodule

// File: tb/tb_image_stream_source.sv
// Directed bench for image_stream_source: a 4x4 single-channel instance for timing, stall and
// reset scenarios, and a 28x28 three-channel instance for channel packing and full-frame length.
module tb_image_stream_source;

    logic clk = 1'b0;
    logic rst_n;

    int vecCnt  = 0;
    int missCnt = 0;

    int pixVal[$];
    int pixCyc[$];
    int doneCyc;
    int busyCnt;
    int maxOcc;
    bit rdInStall;

    image_stream_source_if #(.D_WIDTH(8), .D_CHANNELS(1), .ADDR_WIDTH(4))  if4 ();
    image_stream_source_if #(.D_WIDTH(8), .D_CHANNELS(3), .ADDR_WIDTH(10)) if28 ();

    image_stream_source #(
        .D_WIDTH(8), .D_CHANNELS(1), .IMAGE_SIZE(4), .ADDR_WIDTH(4)
    ) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4)
    );

    image_stream_source #(
        .D_WIDTH(8), .D_CHANNELS(3), .IMAGE_SIZE(28), .ADDR_WIDTH(10)
    ) dut28 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if28)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM models: RAM[a] = a, and RAM[a] = {a+2, a+1, a} per byte.
    always @(posedge clk) begin
        if (if4.mem_rd_en) begin
            if4.mem_rd_data <= {4'd0, if4.mem_addr};
        end
    end

    always @(posedge clk) begin
        if (if28.mem_rd_en) begin
            if28.mem_rd_data <= {if28.mem_addr[7:0] + 8'd2, if28.mem_addr[7:0] + 8'd1,
                                 if28.mem_addr[7:0]};
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vecCnt++;
        if (observed !== expected) begin
            missCnt++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Pulses start on the 4x4 instance and records one frame; cycle 1 is the cycle after the
    // edge that samples start. Returns one cycle past frame_done.
    task automatic applyStimulus(input int stallMode, input bit holdStart);
        pixVal.delete();
        pixCyc.delete();
        doneCyc   = -1;
        busyCnt   = 0;
        maxOcc    = 0;
        rdInStall = 1'b0;
        if4.start = 1'b1;
        @(posedge clk);
        #1;
        if4.start = holdStart;
        for (int c = 1; c <= 200; c++) begin
            case (stallMode)
                1:       if4.stall = (c >= 5) && (c <= 9);
                2:       if4.stall = (c % 2 == 1);
                default: if4.stall = 1'b0;
            endcase
            @(negedge clk);
            if (if4.pixel_en) begin
                pixVal.push_back(int'(if4.pixel_data));
                pixCyc.push_back(c);
            end
            if (if4.busy) busyCnt++;
            if (if4.stall && if4.mem_rd_en) rdInStall = 1'b1;
            if (int'(dut4.u_fifo.occ_o) > maxOcc) maxOcc = int'(dut4.u_fifo.occ_o);
            if (if4.frame_done) begin
                doneCyc = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        if4.stall = 1'b0;
    endtask

    task automatic verifyRaster(input string tag);
        checkOutput({tag, "Cnt"}, pixVal.size(), 16);
        for (int i = 0; i < pixVal.size(); i++) begin
            checkOutput({tag, "Px"}, pixVal[i], i);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "RdEn"}, if4.mem_rd_en, 0);
        checkOutput({tag, "Addr"}, if4.mem_addr, 0);
        checkOutput({tag, "Data"}, if4.pixel_data, 0);
        checkOutput({tag, "PixEn"}, if4.pixel_en, 0);
        checkOutput({tag, "Busy"}, if4.busy, 0);
        checkOutput({tag, "Done"}, if4.frame_done, 0);
    endtask

    initial begin
        int       k;
        int       idx;
        int       done28;
        bit       found;
        logic [7:0]  a8;
        logic [23:0] expWord;

        rst_n      = 1'b0;
        if4.start  = 1'b0;
        if4.stall  = 1'b0;
        if28.start = 1'b0;
        if28.stall = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("rst");
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Plain frame: pixels in cycles 3..18, frame_done in 19, busy 1..19.
        applyStimulus(0, 1'b0);
        checkOutput("t1Done", doneCyc, 19);
        checkOutput("t1Busy", busyCnt, 19);
        verifyRaster("t1");
        if (pixCyc.size() == 16) begin
            for (int i = 0; i < 16; i++) checkOutput("t1Cyc", pixCyc[i], 3 + i);
        end
        @(negedge clk);
        checkOutput("t1BusyLow", if4.busy, 0);
        @(posedge clk);
        #1;

        // Stall in cycles 5..9: pixels 0,1 then gap, pixel 2 resumes in cycle 10.
        applyStimulus(1, 1'b0);
        checkOutput("t2Done", doneCyc, 24);
        checkOutput("t2OccMax", maxOcc, 2);
        checkOutput("t2RdInStall", rdInStall, 0);
        verifyRaster("t2");
        if (pixCyc.size() == 16) begin
            for (int i = 0; i < 16; i++) checkOutput("t2Cyc", pixCyc[i], (i < 2) ? 3 + i : 8 + i);
        end

        // Stall toggling every cycle.
        applyStimulus(2, 1'b0);
        checkOutput("t3DoneSeen", doneCyc > 0, 1);
        checkOutput("t3OccLe2", maxOcc <= 2, 1);
        verifyRaster("t3");

        // Start held high: one frame, then a restart from address 0 right after IDLE.
        applyStimulus(0, 1'b1);
        checkOutput("t4Done", doneCyc, 19);
        verifyRaster("t4");
        @(negedge clk);
        checkOutput("t4IdleBusy", if4.busy, 0);
        checkOutput("t4IdleDone", if4.frame_done, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("t4F2Busy", if4.busy, 1);
        checkOutput("t4F2RdEn", if4.mem_rd_en, 1);
        checkOutput("t4F2Addr", if4.mem_addr, 0);
        if4.start = 1'b0;
        k     = 0;
        found = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (if4.pixel_en) begin
                checkOutput("t4F2Px", if4.pixel_data, k);
                k++;
            end
            if (if4.frame_done) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("t4F2Cnt", k, 16);
        checkOutput("t4F2DoneSeen", found, 1);
        @(posedge clk);
        #1;

        // Reset while pixel 7 is presented, then a clean frame from address 0.
        if4.start = 1'b1;
        @(posedge clk);
        #1;
        if4.start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (if4.pixel_en && (if4.pixel_data == 8'd7)) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("t5Seen7", found, 1);
        #1;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("t5Mid");
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("t5PostBusy", if4.busy, 0);
        checkOutput("t5PostPixEn", if4.pixel_en, 0);
        @(posedge clk);
        #1;
        applyStimulus(0, 1'b0);
        checkOutput("t5Done", doneCyc, 19);
        verifyRaster("t5");
        if (pixCyc.size() > 0) checkOutput("t5First", pixCyc[0], 3);

        // Three packed channels on a 28x28 frame.
        if28.start = 1'b1;
        @(posedge clk);
        #1;
        if28.start = 1'b0;
        idx    = 0;
        done28 = -1;
        for (int c = 1; c <= 900; c++) begin
            @(negedge clk);
            if (if28.pixel_en) begin
                a8      = 8'(idx);
                expWord = {a8 + 8'd2, a8 + 8'd1, a8};
                checkOutput("t6Ch0", if28.pixel_data[7:0], a8);
                checkOutput("t6Word", if28.pixel_data, expWord);
                idx++;
            end
            if (if28.frame_done) begin
                done28 = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        checkOutput("t6Cnt", idx, 784);
        checkOutput("t6Done", done28, 787);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
        $finish;
    end

endmodule
